// File: rtl/wash_run_if.sv
// Setup-stage <-> wash executor signal bundle.
// master: setup stage / stimulus side; slave: the wash_run executor.
interface wash_run_if;
  logic               start;
  logic [1:0]         mode;
  logic [4:0]         weight;
  logic signed [11:0] bal_in;
  logic               pause;
  logic               busy;
  logic [2:0]         phase_led;
  logic [11:0]        rem_bcd;
  logic signed [11:0] bal_out;
  logic               bal_upd;
  logic               rej;
  logic               done;
  logic               buzzer;

  modport master (
    output start, mode, weight, bal_in, pause,
    input  busy, phase_led, rem_bcd, bal_out, bal_upd, rej, done, buzzer
  );

  modport slave (
    input  start, mode, weight, bal_in, pause,
    output busy, phase_led, rem_bcd, bal_out, bal_upd, rej, done, buzzer
  );
endinterface

// File: rtl/wash_run.sv
// Washing-cycle executor: fee check/deduction, wash/rinse/spin sequencing on a 1 s tick, BCD countdown.
// Optional completion buzzer enabled by defining WASH_ALARM_EN.
module wash_run #(
  parameter int unsigned TICK_CYCLES  = 100_000_000,
  parameter int unsigned ALARM_CYCLES = 250_000_000
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  wash_run_if.slave bus
);

  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  if (TICK_CYCLES == 0 || ALARM_CYCLES == 0) begin : g_cfg_err
    $error("wash_run: TICK_CYCLES and ALARM_CYCLES must be nonzero");
  end

  typedef enum logic [2:0] {S_IDLE, S_WASH, S_RINSE, S_SPIN, S_DONE} state_e;

  // Per-mode program table
  function automatic logic [4:0] wash_len(input logic [1:0] m);
    case (m)
      2'd0:    return 5'd0;
      2'd1:    return 5'd10;
      2'd2:    return 5'd15;
      default: return 5'd20;
    endcase
  endfunction

  function automatic logic [4:0] rinse_len(input logic [1:0] m);
    case (m)
      2'd0:    return 5'd0;
      2'd1:    return 5'd6;
      2'd2:    return 5'd8;
      default: return 5'd10;
    endcase
  endfunction

  function automatic logic [4:0] spin_len(input logic [1:0] m);
    case (m)
      2'd0:    return 5'd5;
      2'd1:    return 5'd4;
      2'd2:    return 5'd5;
      default: return 5'd6;
    endcase
  endfunction

  function automatic logic [11:0] fee_of(input logic [1:0] m);
    case (m)
      2'd0:    return 12'd3;
      2'd1:    return 12'd5;
      2'd2:    return 12'd8;
      default: return 12'd12;
    endcase
  endfunction

  function automatic logic [4:0] max_w_of(input logic [1:0] m);
    case (m)
      2'd0:    return 5'd20;
      2'd1:    return 5'd5;
      2'd2:    return 5'd10;
      default: return 5'd20;
    endcase
  endfunction

  // Total seconds of the program, already in BCD
  function automatic logic [11:0] total_bcd(input logic [1:0] m);
    case (m)
      2'd0:    return 12'h005;
      2'd1:    return 12'h020;
      2'd2:    return 12'h028;
      default: return 12'h036;
    endcase
  endfunction

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] h, t, u;
    {h, t, u} = v;
    if (u != 4'd0) begin
      u = u - 4'd1;
    end else begin
      u = 4'd9;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = 4'd9;
        h = h - 4'd1;
      end
    end
    return {h, t, u};
  endfunction

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [4:0]         phase_q, phase_d;
  logic [11:0]        rem_q, rem_d;
  logic signed [11:0] bal_q, bal_d;
  logic [1:0]         mode_q, mode_d;
  logic               bal_upd_q, bal_upd_d;
  logic               rej_q, rej_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [2:0]         led_q, led_d;
  logic               accept_c;

`ifdef WASH_ALARM_EN
  localparam int unsigned ALARM_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_CYCLES - 1);
  logic [ALARM_W-1:0] alarm_q, alarm_d;
  logic               buzzer_q, buzzer_d;
`endif

  assign accept_c = ($signed(bus.bal_in) >= $signed(fee_of(bus.mode))) &&
                    (bus.weight <= max_w_of(bus.mode)) && (bus.weight != 5'd0);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    phase_d   = phase_q;
    rem_d     = rem_q;
    bal_d     = bal_q;
    mode_d    = mode_q;
    bal_upd_d = 1'b0;
    rej_d     = 1'b0;
    done_d    = 1'b0;
`ifdef WASH_ALARM_EN
    alarm_d   = alarm_q;
    buzzer_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (accept_c) begin
            bal_d     = bus.bal_in - $signed(fee_of(bus.mode));
            bal_upd_d = 1'b1;
            rem_d     = total_bcd(bus.mode);
            mode_d    = bus.mode;
            tick_d    = '0;
            if (wash_len(bus.mode) != 5'd0) begin
              state_d = S_WASH;
              phase_d = wash_len(bus.mode);
            end else begin
              state_d = S_SPIN;
              phase_d = spin_len(bus.mode);
            end
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      S_WASH, S_RINSE, S_SPIN: begin
        if (!bus.pause) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            rem_d   = bcd_dec(rem_q);
            phase_d = phase_q - 5'd1;
            if (rem_q == 12'h001) begin
              state_d = S_DONE;
              done_d  = 1'b1;
`ifdef WASH_ALARM_EN
              alarm_d  = '0;
              buzzer_d = 1'b1;
`endif
            end else if (phase_q == 5'd1) begin
              // Advance to the next phase with nonzero length
              if (state_q == S_WASH && rinse_len(mode_q) != 5'd0) begin
                state_d = S_RINSE;
                phase_d = rinse_len(mode_q);
              end else begin
                state_d = S_SPIN;
                phase_d = spin_len(mode_q);
              end
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      S_DONE: begin
`ifdef WASH_ALARM_EN
        if (alarm_q == ALARM_LAST) begin
          state_d = S_IDLE;
        end else begin
          alarm_d  = alarm_q + ALARM_W'(1);
          buzzer_d = 1'b1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WASH) || (state_d == S_RINSE) || (state_d == S_SPIN);
    case (state_d)
      S_WASH:  led_d = 3'b001;
      S_RINSE: led_d = 3'b010;
      S_SPIN:  led_d = 3'b100;
      default: led_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      phase_q   <= '0;
      rem_q     <= '0;
      bal_q     <= '0;
      mode_q    <= '0;
      bal_upd_q <= 1'b0;
      rej_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      phase_q   <= phase_d;
      rem_q     <= rem_d;
      bal_q     <= bal_d;
      mode_q    <= mode_d;
      bal_upd_q <= bal_upd_d;
      rej_q     <= rej_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      led_q     <= led_d;
    end
  end

`ifdef WASH_ALARM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alarm_q  <= '0;
      buzzer_q <= 1'b0;
    end else begin
      alarm_q  <= alarm_d;
      buzzer_q <= buzzer_d;
    end
  end
  assign bus.buzzer = buzzer_q;
`else
  assign bus.buzzer = 1'b0;
`endif

  assign bus.busy      = busy_q;
  assign bus.phase_led = led_q;
  assign bus.rem_bcd   = rem_q;
  assign bus.bal_out   = bal_q;
  assign bus.bal_upd   = bal_upd_q;
  assign bus.rej       = rej_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_wash_run.sv
// Bench for wash_run: directed programs, a seconds-level reference model checked every cycle.
module tb_wash_run;
  localparam int TICK  = 4;
  localparam int ALARM = 10;
`ifdef WASH_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  wash_run_if bus();

  wash_run #(.TICK_CYCLES(TICK), .ALARM_CYCLES(ALARM)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  // Program table in seconds: wash, rinse, spin, fee, max weight
  int WASH_T [4] = '{0, 10, 15, 20};
  int RINSE_T[4] = '{0, 6, 8, 10};
  int SPIN_T [4] = '{5, 4, 5, 6};
  int FEE_T  [4] = '{3, 5, 8, 12};
  int MAXW_T [4] = '{20, 5, 10, 20};

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: 0 idle, 1 running, 2 done/alarm
  int m_state, m_mode, m_cnt, m_age, m_bal;
  bit m_upd, m_rej, m_done;

  function automatic int to_bcd(input int s);
    return (s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10);
  endfunction

  function automatic int total_s(input int m);
    return WASH_T[m] + RINSE_T[m] + SPIN_T[m];
  endfunction

  task automatic model_reset();
    m_state = 0; m_mode = 0; m_cnt = 0; m_age = 0; m_bal = 0;
    m_upd = 0; m_rej = 0; m_done = 0;
  endtask

  task automatic model_step();
    int m;
    m_upd = 0; m_rej = 0; m_done = 0;
    case (m_state)
      0: if (bus.start) begin
           m = int'(bus.mode);
           if (int'(bus.bal_in) >= FEE_T[m] && int'(bus.weight) <= MAXW_T[m] && bus.weight != 0) begin
             m_state = 1; m_mode = m; m_cnt = 0;
             m_bal = int'(bus.bal_in) - FEE_T[m];
             m_upd = 1;
           end else begin
             m_rej = 1;
           end
         end
      1: begin
           if (!bus.pause) m_cnt++;
           if (m_cnt == total_s(m_mode) * TICK) begin
             m_state = 2; m_done = 1; m_age = 0;
           end
         end
      default: begin
           m_age++;
           if (!ALARM_ON || m_age == ALARM) m_state = 0;
         end
    endcase
  endtask

  task automatic model_compare();
    int secs, led, rem;
    secs = m_cnt / TICK;
    rem  = 0;
    led  = 0;
    if (m_state == 1) begin
      rem = to_bcd(total_s(m_mode) - secs);
      if (secs < WASH_T[m_mode])                          led = 1;
      else if (secs < WASH_T[m_mode] + RINSE_T[m_mode])   led = 2;
      else                                                led = 4;
    end
    check("busy",      int'(bus.busy),      int'(m_state == 1));
    check("phase_led", int'(bus.phase_led), led);
    check("rem_bcd",   int'(bus.rem_bcd),   rem);
    check("bal_out",   int'(bus.bal_out),   m_bal);
    check("bal_upd",   int'(bus.bal_upd),   int'(m_upd));
    check("rej",       int'(bus.rej),       int'(m_rej));
    check("done",      int'(bus.done),      int'(m_done));
    check("buzzer",    int'(bus.buzzer),    int'(m_state == 2 && ALARM_ON));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
      else       model_reset();
      @(negedge clk);
      if (!rst_n) model_reset();
      model_compare();
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc_n++;
    end
    #2;
  endtask

  task automatic request(input int m, input int w, input int b);
    bus.mode   = 2'(m);
    bus.weight = 5'(w);
    bus.bal_in = 12'(b);
    bus.start  = 1'b1;
    cyc(1);
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int t0, input int exp);
    int seen;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    check({name, "_seen"}, seen, 1);
    check({name, "_cycles"}, cyc_n - t0, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t0, cnt, frozen;
    bus.start = 1'b0; bus.mode = '0; bus.weight = '0; bus.bal_in = '0; bus.pause = 1'b0;
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_rem",  int'(bus.rem_bcd), 0);
    check("rst_bal",  int'(bus.bal_out), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // Small wash
    request(1, 3, 20);
    t0 = cyc_n;
    check("sw_bal",  int'(bus.bal_out), 15);
    check("sw_upd",  int'(bus.bal_upd), 1);
    check("sw_rem",  int'(bus.rem_bcd), 'h020);
    check("sw_led",  int'(bus.phase_led), 1);
    cyc(39);
    check("sw_wash_end", int'(bus.phase_led), 1);
    cyc(1);
    check("sw_rinse", int'(bus.phase_led), 2);
    cyc(24);
    check("sw_spin",  int'(bus.phase_led), 4);
    wait_done("sw_done", t0, 80);
    cnt = 0;
    repeat (20) begin
      if (bus.buzzer) cnt++;
      cyc(1);
    end
    check("sw_buzz_len", cnt, ALARM_ON ? ALARM : 0);

    // Insufficient balance
    request(3, 5, 11);
    check("nobal_rej",  int'(bus.rej), 1);
    check("nobal_bal",  int'(bus.bal_out), 15);
    check("nobal_busy", int'(bus.busy), 0);
    cyc(1);
    check("nobal_rej_drop", int'(bus.rej), 0);

    // Overweight then at the limit
    request(2, 11, 50);
    check("ovw_rej", int'(bus.rej), 1);
    cyc(1);
    request(2, 10, 50);
    t0 = cyc_n;
    check("lim_rem", int'(bus.rem_bcd), 'h028);
    check("lim_bal", int'(bus.bal_out), 42);
    wait_done("lim_done", t0, 112);
    cyc(15);

    // Spin-only with a 7-cycle pause mid-tick
    request(0, 20, 42);
    t0 = cyc_n;
    check("spin_led", int'(bus.phase_led), 4);
    check("spin_rem", int'(bus.rem_bcd), 'h005);
    check("spin_bal", int'(bus.bal_out), 39);
    cyc(6);
    check("spin_rem_1", int'(bus.rem_bcd), 'h004);
    frozen = int'(bus.rem_bcd);
    bus.pause = 1'b1;
    cyc(7);
    check("spin_frozen", int'(bus.rem_bcd), frozen);
    bus.pause = 1'b0;
    wait_done("spin_done", t0, 27);
    cyc(15);

    // Reset during rinse, then restart with BCD borrow
    request(1, 3, 39);
    check("rs_bal", int'(bus.bal_out), 34);
    cyc(50);
    check("rs_rinse", int'(bus.phase_led), 2);
    rst_n = 1'b0;
    #1;
    check("rs_busy", int'(bus.busy), 0);
    check("rs_led",  int'(bus.phase_led), 0);
    check("rs_rem",  int'(bus.rem_bcd), 0);
    check("rs_bal0", int'(bus.bal_out), 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    request(3, 15, 50);
    t0 = cyc_n;
    check("bw_rem36", int'(bus.rem_bcd), 'h036);
    check("bw_bal",   int'(bus.bal_out), 38);
    cyc(4);
    check("bw_rem35", int'(bus.rem_bcd), 'h035);
    cyc(20);
    check("bw_rem30", int'(bus.rem_bcd), 'h030);
    cyc(4);
    check("bw_rem29", int'(bus.rem_bcd), 'h029);
    wait_done("bw_done", t0, 144);
    cyc(15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wash_run.md
# wash_run

Washing-cycle executor sitting downstream of the pre-wash setup stage (balance entry, mode select, weight entry). It consumes the setup stage's start strobe, mode, weight and balance:
- checks affordability and the load limit;
- deducts the fee;
- sequences the wash, rinse and spin phases on a 1 s time base, showing remaining seconds as BCD for the scanned 7-segment driver;
- signals completion, with an optional buzzer.

## Interface
Parameters:
- TICK_CYCLES, 100_000_000, clk cycles per 1 s tick (100 MHz board clock)
- ALARM_CYCLES, 250_000_000, buzzer duration in clk cycles (2.5 s)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  start request from setup stage (level; sampled only in IDLE)
- mode  in  2  00 spin-only, 01 small, 10 medium, 11 large
- weight  in  5  load in kg, 0..31
- bal_in  in  12 signed  current balance, 0..999
- pause  in  1  lid open; freezes time base while high
- busy  out  1  high in WASH/RINSE/SPIN
- phase_led  out  3  one-hot: [0] wash, [1] rinse, [2] spin; 000 otherwise
- rem_bcd  out  12  remaining seconds, three BCD digits {hundreds, tens, units}
- bal_out  out  12 signed  balance after deduction
- bal_upd  out  1  one-cycle pulse when bal_out is written
- rej  out  1  one-cycle pulse when a start is refused
- done  out  1  one-cycle pulse on entry to DONE
- buzzer  out  1  alarm drive

## Operation
- States: IDLE, WASH, RINSE, SPIN, DONE.
- Per-mode table, as phase seconds wash/rinse/spin, fee, and max weight:
  - 00: 0/0/5, fee 3, max 20
  - 01: 10/6/4, fee 5, max 5
  - 10: 15/8/5, fee 8, max 10
  - 11: 20/10/6, fee 12, max 20
- IDLE with start=1 is accepted when bal_in >= fee, weight <= max and weight != 0. On accept:
  - bal_out <= bal_in - fee, with 12-bit signed subtraction; the result is never negative.
  - Pulse bal_upd.
  - Load rem_bcd with wash+rinse+spin total in BCD.
  - Load the phase counter with the first nonzero phase; mode 00 goes straight to SPIN.
- IDLE with start=1 that fails any check: pulse rej. State, bal_out and rem_bcd are unchanged.
- start held high re-evaluates every IDLE cycle. The setup stage must drop it after acceptance; any start outside IDLE is ignored.
- Tick counter runs 0..TICK_CYCLES-1 only while busy and pause=0. Pause holds the count (no reset).
- On each tick:
  - rem_bcd decrements as a BCD down-counter (units 0 borrows from tens, tens 0 from hundreds).
  - The phase counter decrements. At 0 the state advances WASH->RINSE->SPIN, skipping zero-length phases.
- When rem_bcd reaches 000 on a tick: go to DONE, pulse done, phase_led=000, busy=0.
- DONE: buzzer=1 for ALARM_CYCLES cycles (pause ignored), then IDLE.
- Reset mid-cycle aborts immediately with no refund; bal_out returns to 0.

## Timing
- Reset values: busy 0, phase_led 000, rem_bcd 000, bal_out 0, bal_upd 0, rej 0, done 0, buzzer 0, state IDLE, tick counter 0.
- Accept at edge N: busy, phase_led, rem_bcd, bal_out valid from edge N+1. bal_upd is high for cycle N+1 only.
- rej is high for the single cycle after the sampling edge.
- First tick occurs TICK_CYCLES unpaused cycles after entering WASH/SPIN. Phase change and rem decrement happen on the same edge.
- done rises on the edge of the final tick and stays one cycle.
- DONE->IDLE is exactly ALARM_CYCLES cycles after DONE entry. start is not sampled in DONE.
- Tick and pause rising on the same edge: the tick counts; pause applies from the next cycle.

## Configuration
- WASH_ALARM_EN defined: DONE holds buzzer high for ALARM_CYCLES as above.
- WASH_ALARM_EN undefined: buzzer tied 0, alarm counter removed, and DONE lasts one cycle before IDLE. done still pulses.

## Test plan
Run with TICK_CYCLES=4, ALARM_CYCLES=10.
- **Small wash:** mode=01, weight=3, bal_in=20, start pulse -> bal_out=15, bal_upd one cycle, rem_bcd=020, phase_led=001. RINSE after 10 ticks, SPIN after 16. done after 20 ticks (80 cycles), buzzer 10 cycles, then IDLE.
- **Insufficient balance:** mode=11, bal_in=11 -> rej pulse, bal_out unchanged, busy stays 0.
- **Overweight:** mode=10, weight=11, bal_in=50 -> rej. Same setup with weight=10 -> accepted, rem_bcd=028.
- **Spin-only with pause:** mode=00, weight=20 -> phase_led=100, rem_bcd=005. pause high 7 cycles mid-tick -> completion delayed exactly 7 cycles; rem_bcd frozen meanwhile.
- **Restart and borrow:** rst low during RINSE -> all outputs at reset values next cycle. Restart with mode=11 -> rem_bcd 036 then 035..030, 029 (tens borrow correct).
